// File: rtl/nco_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nco_pkg
//  Description : Shared widths, phase/angle types and helpers for the
//                multi-channel NCO phase driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package nco_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int ACC_W_DEF  = 32;
  localparam int OUT_W_DEF  = 20;

  typedef logic [ACC_W_DEF-1:0] phase_t;
  typedef logic [OUT_W_DEF-1:0] angle_t;

  // Channel-index width; a single channel still needs a 1-bit index port.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nco_phase_acc.sv
`default_nettype none
// ============================================================================
//  Module      : nco_phase_acc
//  Description : One NCO channel: phase accumulator, active increment,
//                shadow increment/offset, sync reload and carry-out pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module nco_phase_acc
  import nco_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             sync_i,       // sync pulse already qualified by this channel's mask bit
  input  logic             cfg_we_i,
  input  logic [ACC_W-1:0] cfg_inc_i,
  input  logic [ACC_W-1:0] cfg_offset_i,
  output logic [ACC_W-1:0] acc_o,
  output logic             wrap_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic [ACC_W-1:0] sh_inc_q, sh_inc_d;
  logic [ACC_W-1:0] sh_off_q, sh_off_d;
  logic             wrap_q, wrap_d;
  logic [ACC_W:0]   sum;

  // Extra MSB captures the carry-out, which is the full-circle wrap indication.
  assign sum = {1'b0, acc_q} + {1'b0, inc_q};

  // Next-state: shadow capture, sync reload (no increment), or free-running advance.
  always_comb begin
    acc_d    = acc_q;
    inc_d    = inc_q;
    sh_inc_d = sh_inc_q;
    sh_off_d = sh_off_q;
    wrap_d   = 1'b0;
    if (cfg_we_i) begin
      sh_inc_d = cfg_inc_i;
      sh_off_d = cfg_offset_i;
    end
    if (sync_i) begin
      inc_d = sh_inc_q;
      acc_d = sh_off_q;
    end else if (en_i) begin
      acc_d  = sum[ACC_W-1:0];
      wrap_d = sum[ACC_W];
    end
  end

  // Channel state registers; reset also discards uncommitted shadow values.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      inc_q    <= '0;
      sh_inc_q <= '0;
      sh_off_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      inc_q    <= inc_d;
      sh_inc_q <= sh_inc_d;
      sh_off_q <= sh_off_d;
      wrap_q   <= wrap_d;
    end
  end

  assign acc_o  = acc_q;
  assign wrap_o = wrap_q;

endmodule
`default_nettype wire

// File: rtl/nco_phase_driver_mc.sv
`default_nettype none
// ============================================================================
//  Module      : nco_phase_driver_mc
//  Description : Multi-channel NCO phase driver. NUM_CH shadowed phase
//                accumulators, sync-committed, issuing one truncated phase
//                per cycle round-robin to a shared downstream rotator.
//  Revision    : 1.0 - initial release
// ============================================================================
module nco_phase_driver_mc
  import nco_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  localparam int CH_W  = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [ACC_W-1:0]  cfg_inc_i,
  input  logic [ACC_W-1:0]  cfg_offset_i,
  input  logic              sync_i,
  input  logic [NUM_CH-1:0] sync_mask_i,
  output logic              out_valid_o,
  output logic [CH_W-1:0]   out_ch_o,
  output logic [OUT_W-1:0]  out_angle_o,
  output logic [NUM_CH-1:0] wrap_o
);

  localparam logic [CH_W-1:0] RR_LAST = CH_W'(NUM_CH - 1);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("nco_phase_driver_mc: NUM_CH must be >= 1");
  end
  if ((OUT_W < 1) || (OUT_W > ACC_W)) begin : g_bad_out_w
    $error("nco_phase_driver_mc: OUT_W must satisfy 1 <= OUT_W <= ACC_W");
  end

  logic [ACC_W-1:0]  acc [NUM_CH];
  logic [NUM_CH-1:0] cfg_we;
  logic              cfg_fire;

  logic [CH_W-1:0]   rr_q, rr_d;
  logic              out_valid_q, out_valid_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [OUT_W-1:0]  out_angle_q, out_angle_d;

  // Config writes are refused during sync so a commit never races a shadow update.
  assign cfg_ready_o = !sync_i && !rst;
  assign cfg_fire    = cfg_valid_i && cfg_ready_o;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range channel indices simply match no channel.
    assign cfg_we[i] = cfg_fire && (cfg_ch_i == CH_W'(i));

    nco_phase_acc #(
      .ACC_W (ACC_W)
    ) u_acc (
      .clk          (clk),
      .rst          (rst),
      .en_i         (en_i),
      .sync_i       (sync_i && sync_mask_i[i]),
      .cfg_we_i     (cfg_we[i]),
      .cfg_inc_i    (cfg_inc_i),
      .cfg_offset_i (cfg_offset_i),
      .acc_o        (acc[i]),
      .wrap_o       (wrap_o[i])
    );
  end

  // Issue the pre-edge phase of the current round-robin channel; sync restarts the rotation.
  always_comb begin
    rr_d        = rr_q;
    out_valid_d = en_i;
    out_ch_d    = out_ch_q;
    out_angle_d = out_angle_q;
    if (en_i) begin
      out_ch_d    = rr_q;
      out_angle_d = acc[rr_q][ACC_W-1 -: OUT_W];
      rr_d        = (rr_q == RR_LAST) ? '0 : rr_q + 1'b1;
    end
    if (sync_i) begin
      rr_d = '0;
    end
  end

  // Round-robin pointer and registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_angle_q <= '0;
    end else begin
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_angle_q <= out_angle_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_ch_o    = out_ch_q;
  assign out_angle_o = out_angle_q;

endmodule
`default_nettype wire
